// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide type definitions: the machine word and its width.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/pipe_reg_stage.sv
// One slot of the register chain: a valid bit plus a payload register.
// clear_i squashes the slot; load_i copies the upstream slot in. A bubble
// loaded from upstream only drops the valid bit and keeps the old payload,
// which avoids toggling the wide data register for nothing.
module pipe_reg_stage
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Next-state selection: clear wins over load, otherwise hold.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    // Slot register with asynchronous reset of both valid and payload.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the payload is reset too, because out_data must read zero
            // while reset is held; this is a handful of flops, not a memory.
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, so stage order in the chain never matters.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : pipe_reg_stage

// File: rtl/pipe_reg_chain.sv
// Valid/ready register chain of DEPTH slots with bubble collapse, a global
// hold (pipeline stall) and a flush that squashes everything in flight.
// Stage 0 is the input side, stage DEPTH-1 drives the output port. Outputs
// depend on registers and on hold/flush/out_ready only, never on the input
// payload, so chains can be cascaded without building long combinational paths.
module pipe_reg_chain
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = $bits(word_t),  // 1..256
    parameter int DEPTH  = 2               // 1..8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       hold,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              step_en;
    logic [DEPTH-1:0]  adv;
    logic [DEPTH-1:0]  stage_v;
    logic [DATA_W-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0]  src_v;
    logic [DATA_W-1:0] src_d [DEPTH];
    logic [OCC_W-1:0]  occ_q, occ_d;

    // Flush overrides hold; either one freezes every transfer this cycle.
    assign step_en = !hold && !flush;

    // A stage may advance when it or any stage downstream of it is empty,
    // or when the output is being taken: this is what collapses bubbles.
    always_comb begin : adv_calc
        logic gap;
        gap = 1'b0;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            gap    = gap || !stage_v[i];
            adv[i] = gap || out_ready;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_src_in
            assign src_v[g] = in_valid;
            assign src_d[g] = in_data;
        end else begin : g_src_prev
            assign src_v[g] = stage_v[g-1];
            assign src_d[g] = stage_d[g-1];
        end

        pipe_reg_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk_i   (CLK),
            .rst_i   (RST),
            .load_i  (step_en && adv[g]),
            .clear_i (flush),
            .valid_i (src_v[g]),
            .data_i  (src_d[g]),
            .valid_o (stage_v[g]),
            .data_o  (stage_d[g])
        );
    end

    // Population count of the valid bits the stages will hold after the edge.
    always_comb begin : occ_calc
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!flush) begin
                if (step_en && adv[i]) begin
                    occ_d = occ_d + OCC_W'(src_v[i]);
                end else begin
                    occ_d = occ_d + OCC_W'(stage_v[i]);
                end
            end
        end
    end

    // Occupancy register, updated on the same edge as the valid bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign in_ready  = adv[0] && step_en;
    assign out_valid = stage_v[DEPTH-1] && step_en;
    assign out_data  = stage_d[DEPTH-1];
    assign occupancy = occ_q;

endmodule : pipe_reg_chain

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: two instances (DEPTH=2 and DEPTH=3) driven by
// directed sequences and then random traffic. Each instance has a monitor
// that keeps an in-order queue of accepted payloads and a count of items in
// flight, predicts in_ready/occupancy from that count, and compares every
// payload the chain delivers against the queue head.
module tb_pipe_reg_chain;
    import cpu_types_pkg::*;

    localparam int D_A = 2;
    localparam int D_B = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic  a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_hold, a_flush;
    word_t a_in_data, a_out_data;
    logic [$clog2(D_A+1)-1:0] a_occ;

    logic  b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_hold, b_flush;
    word_t b_in_data, b_out_data;
    logic [$clog2(D_B+1)-1:0] b_occ;

    pipe_reg_chain #(.DATA_W($bits(word_t)), .DEPTH(D_A)) u_dut_a (
        .CLK(clk), .RST(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .hold(a_hold), .flush(a_flush), .occupancy(a_occ)
    );

    pipe_reg_chain #(.DATA_W($bits(word_t)), .DEPTH(D_B)) u_dut_b (
        .CLK(clk), .RST(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .hold(b_hold), .flush(b_flush), .occupancy(b_occ)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: accepted-but-not-delivered payloads in order.
    word_t q_a[$];
    word_t q_b[$];
    int    cnt_a = 0, cnt_b = 0;
    int    rx_a  = 0, rx_b  = 0;

    always @(negedge clk) begin : mon_a
        bit exp_rdy, xin, xout;
        if (rst) begin
            check("a_rst_out_valid", a_out_valid, 1'b0);
            check("a_rst_out_data", a_out_data, '0);
            check("a_rst_occ", a_occ, '0);
            q_a.delete();
            cnt_a = 0;
        end else begin
            check("a_occ", a_occ, cnt_a);
            exp_rdy = !a_hold && !a_flush && (cnt_a < D_A || a_out_ready);
            check("a_in_ready", a_in_ready, exp_rdy);
            if (a_hold || a_flush) check("a_out_valid_stalled", a_out_valid, 1'b0);
            xout = a_out_valid && a_out_ready;
            xin  = a_in_valid && exp_rdy;
            if (xout) begin
                check("a_out_pending", q_a.size() > 0, 1'b1);
                if (q_a.size() > 0) check("a_out_data", a_out_data, q_a.pop_front());
                rx_a++;
            end
            if (xin) q_a.push_back(a_in_data);
            if (a_flush) begin
                q_a.delete();
                cnt_a = 0;
            end else begin
                cnt_a = cnt_a + int'(xin) - int'(xout);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        bit exp_rdy, xin, xout;
        if (rst) begin
            check("b_rst_out_valid", b_out_valid, 1'b0);
            check("b_rst_out_data", b_out_data, '0);
            check("b_rst_occ", b_occ, '0);
            q_b.delete();
            cnt_b = 0;
        end else begin
            check("b_occ", b_occ, cnt_b);
            exp_rdy = !b_hold && !b_flush && (cnt_b < D_B || b_out_ready);
            check("b_in_ready", b_in_ready, exp_rdy);
            if (b_hold || b_flush) check("b_out_valid_stalled", b_out_valid, 1'b0);
            xout = b_out_valid && b_out_ready;
            xin  = b_in_valid && exp_rdy;
            if (xout) begin
                check("b_out_pending", q_b.size() > 0, 1'b1);
                if (q_b.size() > 0) check("b_out_data", b_out_data, q_b.pop_front());
                rx_b++;
            end
            if (xin) q_b.push_back(b_in_data);
            if (b_flush) begin
                q_b.delete();
                cnt_b = 0;
            end else begin
                cnt_b = cnt_b + int'(xin) - int'(xout);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int    sent;
        int    rx0;
        logic [1:0] occ_frozen;
        word_t data_frozen;

        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_hold = 0; a_flush = 0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_hold = 0; b_flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a_out_valid", a_out_valid, 1'b0);
        check("reset_a_occ", a_occ, '0);
        check("reset_b_out_data", b_out_data, '0);
        rst = 1'b0;

        // Streaming through DEPTH=2: first payload appears two edges later.
        a_out_ready = 1; a_in_valid = 1; a_in_data = 32'h11;
        tick();
        check("stream_not_yet", a_out_valid, 1'b0);
        a_in_data = 32'h22;
        tick();
        check("stream_v1", a_out_valid, 1'b1);
        check("stream_d1", a_out_data, 32'h11);
        a_in_data = 32'h33;
        tick();
        check("stream_d2", a_out_data, 32'h22);
        a_in_valid = 0;
        tick();
        check("stream_d3", a_out_data, 32'h33);
        tick();
        check("stream_empty", a_out_valid, 1'b0);

        // Backpressure on DEPTH=3: three accepted, fourth refused.
        b_out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            b_in_valid = 1; b_in_data = 32'hB0 + k;
            #1;
            check("bp_in_ready", b_in_ready, k < 3);
            check("bp_occ", b_occ, k);
            tick();
        end
        b_in_valid = 0; b_out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            check("bp_drain_valid", b_out_valid, 1'b1);
            check("bp_drain_data", b_out_data, 32'hB0 + k);
            tick();
        end
        check("bp_drained", b_out_valid, 1'b0);

        // Bubble collapse: AA, idle, BB with output blocked -> packed.
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = 32'hAA; tick();
        b_in_valid = 0; tick();
        b_in_valid = 1; b_in_data = 32'hBB; tick();
        b_in_valid = 0; tick();
        tick();
        check("bubble_occ", b_occ, 2);
        check("bubble_head", b_out_data, 32'hAA);
        b_out_ready = 1;
        tick();
        check("bubble_next_valid", b_out_valid, 1'b1);
        check("bubble_next_data", b_out_data, 32'hBB);
        tick();
        check("bubble_done", b_out_valid, 1'b0);
        b_out_ready = 0;

        // Hold for three cycles in the middle of a stream.
        a_out_ready = 1; sent = 0; rx0 = rx_a;
        occ_frozen = '0; data_frozen = '0;
        for (int c = 0; c < 20; c++) begin
            a_hold     = (c >= 3 && c < 6);
            a_in_valid = (sent < 8);
            a_in_data  = 32'hC0 + sent;
            #1;
            if (c == 3) begin
                occ_frozen  = a_occ;
                data_frozen = a_out_data;
            end
            if (a_hold) begin
                check("hold_in_ready", a_in_ready, 1'b0);
                check("hold_out_valid", a_out_valid, 1'b0);
                check("hold_occ", a_occ, occ_frozen);
                check("hold_data", a_out_data, data_frozen);
            end
            if (a_in_valid && a_in_ready) sent++;
            tick();
        end
        a_hold = 0; a_in_valid = 0;
        check("hold_sent", sent, 8);
        check("hold_received", rx_a - rx0, 8);

        // Flush of a full chain, with hold and a new offer in the same cycle.
        b_out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            b_in_valid = 1; b_in_data = 32'hD0 + k; tick();
        end
        check("flush_full", b_occ, 3);
        b_in_valid = 1; b_in_data = 32'hEE; b_flush = 1; b_hold = 1;
        #1;
        check("flush_in_ready", b_in_ready, 1'b0);
        check("flush_out_valid", b_out_valid, 1'b0);
        tick();
        b_flush = 0; b_hold = 0; b_in_valid = 0;
        #1;
        check("flush_occ", b_occ, 0);
        check("flush_after_valid", b_out_valid, 1'b0);
        b_out_ready = 1;
        repeat (4) tick();
        check("flush_nothing_out", b_out_valid, 1'b0);

        // Asynchronous reset between edges with two payloads in flight.
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'h05; tick();
        a_in_data = 32'h06; tick();
        a_in_valid = 0;
        check("arst_pre_occ", a_occ, 2);
        check("arst_pre_valid", a_out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", a_out_valid, 1'b0);
        check("arst_out_data", a_out_data, '0);
        check("arst_occ", a_occ, '0);
        tick();
        tick();
        rst = 1'b0;
        a_in_valid = 1; a_in_data = 32'h5A; a_out_ready = 1;
        tick();
        a_in_valid = 0;
        check("arst_lat_1", a_out_valid, 1'b0);
        tick();
        check("arst_lat_valid", a_out_valid, 1'b1);
        check("arst_lat_data", a_out_data, 32'h5A);
        tick();

        // Random traffic on both chains.
        for (int c = 0; c < 1500; c++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = $urandom;
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_hold      = ($urandom_range(0, 15) == 0);
            a_flush     = ($urandom_range(0, 31) == 0);
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_data   = $urandom;
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_hold      = ($urandom_range(0, 15) == 0);
            b_flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        a_in_valid = 0; a_hold = 0; a_flush = 0; a_out_ready = 1;
        b_in_valid = 0; b_hold = 0; b_flush = 0; b_out_ready = 1;
        repeat (6) tick();
        check("drain_a_empty", q_a.size(), 0);
        check("drain_b_empty", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pipe_reg_chain

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 32 (WORD_W): payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages, legal range 1..8.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: upstream holds a valid payload.
REQ-006 SHALL have port in_ready, output, 1: the chain accepts the payload this cycle.
REQ-007 SHALL have port in_data, input, DATA_W: upstream payload.
REQ-008 SHALL have port out_valid, output, 1: the last stage presents a valid payload.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts the payload this cycle.
REQ-010 SHALL have port out_data, output, DATA_W: payload of the last stage.
REQ-011 SHALL have port hold, input, 1: global stall, equivalent to a pipeline_control stall from ihit/dhit.
REQ-012 SHALL have port flush, input, 1: squash all in-flight payloads.
REQ-013 SHALL have port occupancy, output, $clog2(DEPTH+1): count of valid stages.

Function
REQ-014 SHALL hold a valid bit v[i] and data register d[i] per stage, i=0 (input side) to DEPTH-1 (output side).
REQ-015 SHALL define stage advance: adv[DEPTH-1] = !v[DEPTH-1] || out_ready; adv[i] = !v[i] || adv[i+1] (bubble collapse).
REQ-016 SHALL drive in_ready = adv[0] && !hold && !flush.
REQ-017 SHALL drive out_valid = v[DEPTH-1] && !hold && !flush; out_data = d[DEPTH-1] at all times.
REQ-018 SHALL count a transfer in when in_valid && in_ready, and a transfer out when out_valid && out_ready.
REQ-019 SHALL, when neither hold nor flush is asserted and adv[i], load stage i from stage i-1 (or from in_data/in_valid for i=0) at the clock edge.
REQ-020 SHALL leave d[i] unchanged whenever stage i does not load; a stage that loads an invalid bubble SHALL clear v[i] and may leave d[i] unchanged.
REQ-021 SHALL have a latency of DEPTH cycles from input transfer to out_valid through an empty, unstalled chain.
REQ-022 SHALL sustain one transfer per cycle when in_valid and out_ready are held high.
REQ-023 SHALL, while hold=1 and flush=0, change no v[i] or d[i]; in_ready=0 and out_valid=0.
REQ-024 SHALL, on flush=1, clear every v[i] at the next edge and perform no transfer in that cycle; flush overrides hold.
REQ-025 SHALL drop an in_valid payload presented in a flush cycle; upstream sees in_ready=0.
REQ-026 SHALL register occupancy as the population count of v[], updated on the same edge as v[].
REQ-027 SHALL never overflow: when full and out_ready=0, in_ready=0 and all stages hold.
REQ-028 SHALL give the same behaviour for DEPTH=1, where adv[0] = !v[0] || out_ready.
REQ-029 SHALL have no combinational path from in_valid or in_data to out_valid or out_data.

Reset
REQ-030 SHALL, while RST=1, asynchronously force all v[i]=0, all d[i]=0 and occupancy=0; outputs SHALL follow: out_valid=0, out_data=0.
REQ-031 SHALL discard all in-flight payloads when RST asserts mid-operation; the first edge after RST deasserts SHALL be usable for a transfer in.

Structure
REQ-032 SHALL use WORD_W and word_t from cpu_types_pkg for defaults; it SHALL add no new package typedefs.
REQ-033 SHALL use one sub-module, pipe_reg_stage (one valid bit plus DATA_W register, load/clear inputs), instantiated DEPTH times in a generate loop.
REQ-034 SHALL compute occupancy in the top module, not in the stages.

Verification
REQ-035 SHALL test streaming: DEPTH=2; 0x11, 0x22 and 0x33 on consecutive cycles with out_ready=1 -> 0x11 at out on cycle 2, then 0x22 and 0x33, one per cycle.
REQ-036 SHALL test backpressure: DEPTH=3 with out_ready=0 and four offers -> three accepted, occupancy=3, in_ready=0 on the fourth; out_ready=1 -> drain in order.
REQ-037 SHALL test bubble collapse: DEPTH=3; 0xAA enters, one idle cycle, then 0xBB, with out_ready=0 -> both packed in stages 2 and 1, occupancy=2.
REQ-038 SHALL test hold: assert hold for 3 cycles mid-stream -> state frozen, in_ready=0 and out_valid=0 throughout; the stream resumes with no loss or duplication.
REQ-039 SHALL test flush: full chain, flush and hold both high with in_valid=1 -> next cycle occupancy=0, out_valid=0, input payload not accepted.
REQ-040 SHALL test async reset: assert RST between edges while occupancy=2 -> out_valid=0 and out_data=0 immediately; after release, 0x5A enters and exits after DEPTH cycles.
